// File: rtl/rob_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// rob_ptr_ctrl
// Reorder-buffer bookkeeping for a 16-entry ROB. It keeps the head/tail
// pointers, the occupancy count and the per-entry allocated/done bits.
// Each cycle it grants up to two ROB indices to dispatch, records completions
// from two execution ports, and retires up to two entries in program order.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    empty the ROB (same next state as reset)
//   alloc_a/alloc_b          dispatch slot requests
//   alloc_idx_a/alloc_idx_b  indices granted to slot A / slot B
//   alloc_ok                 comb: the current request fits in the free space
//   alloc_ovf                registered: the previous request was rejected
//   cmp{0,1}_valid/_idx      completion strobes and ROB indices
//   commit_en                retire stage can accept commits this cycle
//   commit{0,1}_valid/_idx   comb: head / head+1 retire this cycle
//   rob_head, rob_tail       oldest entry / next free entry
//   rob_count                occupied entries, 0..ROB_DEPTH
//   rob_full, rob_empty      count == ROB_DEPTH / count == 0
// -----------------------------------------------------------------------------
module rob_ptr_ctrl #(
  parameter int ROB_DEPTH = 16,
  parameter int PTR_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_a,
  input  logic             alloc_b,
  output logic [PTR_W-1:0] alloc_idx_a,
  output logic [PTR_W-1:0] alloc_idx_b,
  output logic             alloc_ok,
  output logic             alloc_ovf,
  input  logic             cmp0_valid,
  input  logic [PTR_W-1:0] cmp0_idx,
  input  logic             cmp1_valid,
  input  logic [PTR_W-1:0] cmp1_idx,
  input  logic             commit_en,
  output logic             commit0_valid,
  output logic             commit1_valid,
  output logic [PTR_W-1:0] commit0_idx,
  output logic [PTR_W-1:0] commit1_idx,
  output logic [PTR_W-1:0] rob_head,
  output logic [PTR_W-1:0] rob_tail,
  output logic [PTR_W:0]   rob_count,
  output logic             rob_full,
  output logic             rob_empty
);

  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(ROB_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_XC = (PTR_W+2)'(ROB_DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]     head_q, head_d;
  logic [PTR_W-1:0]     tail_q, tail_d;
  logic [PTR_W:0]       count_q, count_d;
  logic [ROB_DEPTH-1:0] alloc_q, alloc_d;
  logic [ROB_DEPTH-1:0] done_q, done_d;
  logic                 ovf_q, ovf_d;

  // ---------------------------------------------------------------------------
  // Allocation
  // ---------------------------------------------------------------------------
  logic [1:0]       n_alloc;
  logic [1:0]       n_alloc_acc;
  logic [PTR_W:0]   free_slots;
  logic [PTR_W-1:0] head_p1;

  assign n_alloc     = {1'b0, alloc_a} + {1'b0, alloc_b};
  // Free space comes from the registered count only; same-cycle retirements
  // do not open up room for this cycle's dispatch.
  assign free_slots  = DEPTH_C - count_q;
  assign alloc_ok    = ((PTR_W+1)'(n_alloc) <= free_slots);
  // All-or-nothing: a rejected pair allocates neither slot.
  assign n_alloc_acc = alloc_ok ? n_alloc : 2'd0;
  assign alloc_idx_a = tail_q;
  assign alloc_idx_b = tail_q + PTR_W'(alloc_a);

  // ---------------------------------------------------------------------------
  // Commit (combinational from registered state)
  // ---------------------------------------------------------------------------
  logic [1:0] n_commit;

  assign head_p1       = head_q + PTR_W'(1);
  // alloc is 0 beyond the tail, so these terms never retire past it.
  assign commit0_valid = commit_en & alloc_q[head_q] & done_q[head_q];
  assign commit1_valid = commit0_valid & alloc_q[head_p1] & done_q[head_p1];
  assign commit0_idx   = head_q;
  assign commit1_idx   = head_p1;
  assign n_commit      = {1'b0, commit0_valid} + {1'b0, commit1_valid};

  // ---------------------------------------------------------------------------
  // Per-entry next state
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < ROB_DEPTH; gi++) begin : g_entry
      logic cmp_hit;
      logic commit_clr;
      logic alloc_set;
      logic alloc_nx;
      logic done_nx;

      assign cmp_hit    = (cmp0_valid && (cmp0_idx == PTR_W'(gi))) ||
                          (cmp1_valid && (cmp1_idx == PTR_W'(gi)));
      assign commit_clr = (commit0_valid && (head_q  == PTR_W'(gi))) ||
                          (commit1_valid && (head_p1 == PTR_W'(gi)));
      assign alloc_set  = alloc_ok &&
                          ((alloc_a && (alloc_idx_a == PTR_W'(gi))) ||
                           (alloc_b && (alloc_idx_b == PTR_W'(gi))));

      // A newly granted entry is never allocated in the same cycle it
      // retires, because a full ROB rejects allocation; the ordering below
      // only matters for completions racing a retirement.
      always_comb begin
        alloc_nx = alloc_q[gi];
        done_nx  = done_q[gi];
        if (cmp_hit && alloc_q[gi]) begin
          done_nx = 1'b1;
        end
        if (commit_clr) begin
          alloc_nx = 1'b0;
          done_nx  = 1'b0;
        end
        if (alloc_set) begin
          alloc_nx = 1'b1;
          done_nx  = 1'b0;
        end
      end

      assign alloc_d[gi] = alloc_nx;
      assign done_d[gi]  = done_nx;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pointer / count next state
  // ---------------------------------------------------------------------------
  logic [PTR_W+1:0] count_plus;

  assign count_plus = {1'b0, count_q} + (PTR_W+2)'(n_alloc_acc);
  assign head_d     = head_q + PTR_W'(n_commit);
  assign tail_d     = tail_q + PTR_W'(n_alloc_acc);
  assign count_d    = count_q + (PTR_W+1)'(n_alloc_acc) - (PTR_W+1)'(n_commit);
  assign ovf_d      = ~alloc_ok;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      alloc_q <= '0;
      done_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      alloc_q <= alloc_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
      // Occupancy must stay within 0..ROB_DEPTH.
      assert ((count_plus >= (PTR_W+2)'(n_commit)) &&
              ((count_plus - (PTR_W+2)'(n_commit)) <= DEPTH_XC));
    end
  end

  // ---------------------------------------------------------------------------
  // Status outputs; full/empty come from the count, never pointer equality.
  // ---------------------------------------------------------------------------
  assign alloc_ovf = ovf_q;
  assign rob_head  = head_q;
  assign rob_tail  = tail_q;
  assign rob_count = count_q;
  assign rob_full  = (count_q == DEPTH_C);
  assign rob_empty = (count_q == '0);

endmodule

// File: tb/tb_rob_ptr_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rob_ptr_ctrl
// Directed and randomized stimulus against a reference model that describes
// the ROB as a head index plus an occupancy (live entries are the window
// head .. head+count-1) and a done flag per entry.
// -----------------------------------------------------------------------------
module tb_rob_ptr_ctrl;

  logic       clk = 1'b0;
  logic       rst, flush, alloc_a, alloc_b;
  logic [3:0] alloc_idx_a, alloc_idx_b;
  logic       alloc_ok, alloc_ovf;
  logic       cmp0_valid, cmp1_valid;
  logic [3:0] cmp0_idx, cmp1_idx;
  logic       commit_en, commit0_valid, commit1_valid;
  logic [3:0] commit0_idx, commit1_idx, rob_head, rob_tail;
  logic [4:0] rob_count;
  logic       rob_full, rob_empty;

  always #5 clk = ~clk;

  rob_ptr_ctrl #(.ROB_DEPTH(16), .PTR_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_a(alloc_a), .alloc_b(alloc_b),
    .alloc_idx_a(alloc_idx_a), .alloc_idx_b(alloc_idx_b),
    .alloc_ok(alloc_ok), .alloc_ovf(alloc_ovf),
    .cmp0_valid(cmp0_valid), .cmp0_idx(cmp0_idx),
    .cmp1_valid(cmp1_valid), .cmp1_idx(cmp1_idx),
    .commit_en(commit_en),
    .commit0_valid(commit0_valid), .commit1_valid(commit1_valid),
    .commit0_idx(commit0_idx), .commit1_idx(commit1_idx),
    .rob_head(rob_head), .rob_tail(rob_tail), .rob_count(rob_count),
    .rob_full(rob_full), .rob_empty(rob_empty)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model state
  int m_head  = 0;
  int m_count = 0;
  bit m_done[16];
  bit m_ovf   = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_miss++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic bit in_rob(input int idx);
    return ((idx - m_head + 16) % 16) < m_count;
  endfunction

  function automatic void model_reset();
    m_head  = 0;
    m_count = 0;
    m_ovf   = 1'b0;
    for (int k = 0; k < 16; k++) m_done[k] = 1'b0;
  endfunction

  // One cycle: drive inputs, compare all outputs against the model, then
  // advance the model by the rules applied at the coming clock edge.
  task automatic step(input bit r, input bit f, input bit a, input bit b,
                      input bit v0, input int i0, input bit v1, input int i1,
                      input bit ce);
    int  tail, na, nc, ia, ib;
    bit  ok, c0, c1;
    @(negedge clk);
    rst = r; flush = f; alloc_a = a; alloc_b = b;
    cmp0_valid = v0; cmp0_idx = 4'(i0);
    cmp1_valid = v1; cmp1_idx = 4'(i1);
    commit_en = ce;
    #1;
    tail = (m_head + m_count) % 16;
    na   = int'(a) + int'(b);
    ok   = (na <= 16 - m_count);
    ia   = tail;
    ib   = (tail + int'(a)) % 16;
    c0   = ce && (m_count >= 1) && m_done[m_head];
    c1   = c0 && (m_count >= 2) && m_done[(m_head + 1) % 16];
    nc   = int'(c0) + int'(c1);

    check_val("alloc_idx_a", 32'(alloc_idx_a), ia);
    check_val("alloc_idx_b", 32'(alloc_idx_b), ib);
    check_val("alloc_ok", 32'(alloc_ok), 32'(ok));
    check_val("alloc_ovf", 32'(alloc_ovf), 32'(m_ovf));
    check_val("commit0_valid", 32'(commit0_valid), 32'(c0));
    check_val("commit1_valid", 32'(commit1_valid), 32'(c1));
    check_val("commit0_idx", 32'(commit0_idx), m_head);
    check_val("commit1_idx", 32'(commit1_idx), (m_head + 1) % 16);
    check_val("rob_head", 32'(rob_head), m_head);
    check_val("rob_tail", 32'(rob_tail), tail);
    check_val("rob_count", 32'(rob_count), m_count);
    check_val("rob_full", 32'(rob_full), 32'(m_count == 16));
    check_val("rob_empty", 32'(rob_empty), 32'(m_count == 0));

    if (r || f) begin
      model_reset();
    end else begin
      if (v0 && in_rob(i0)) m_done[i0] = 1'b1;
      if (v1 && in_rob(i1)) m_done[i1] = 1'b1;
      m_head  = (m_head + nc) % 16;
      m_count = m_count - nc;
      if (ok) begin
        if (a) m_done[ia] = 1'b0;
        if (b) m_done[ib] = 1'b0;
        m_count = m_count + na;
      end
      m_ovf = !ok;
    end
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; alloc_a = 1'b0; alloc_b = 1'b0;
    cmp0_valid = 1'b0; cmp0_idx = '0; cmp1_valid = 1'b0; cmp1_idx = '0;
    commit_en = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset then idle; a completion to an empty ROB must be ignored.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 0, 0, 1);
    idle_step();

    // Dual alloc twice, complete 1 then 0 with retirement enabled.
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0, 1);
    step(0, 0, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle_step();

    // Fill to full, overflow, then the count=15 boundary.
    for (int k = 0; k < 8; k++) step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 2, 1, 2, 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);

    // Flush with same-cycle alloc and completion, then a stale completion.
    step(0, 0, 0, 0, 1, 4, 1, 5, 0);
    step(0, 1, 1, 0, 1, 6, 0, 0, 1);
    step(0, 0, 0, 0, 1, 4, 0, 0, 1);
    idle_step();
    step(0, 0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 0, 0, 0, 1);
    idle_step();

    // Randomized phases: fill-heavy, balanced, drain-heavy.
    for (int n = 0; n < 3000; n++) begin
      int  phase, pa, pc, i0, i1;
      bit  r, f, a, b, v0, v1, ce;
      phase = (n / 200) % 3;
      pa = (phase == 0) ? 90 : (phase == 1) ? 50 : 20;
      pc = (phase == 0) ? 20 : (phase == 1) ? 60 : 90;
      r  = ($urandom_range(0, 499) == 0);
      f  = ($urandom_range(0, 149) == 0);
      a  = ($urandom_range(0, 99) < pa);
      b  = ($urandom_range(0, 99) < pa);
      ce = ($urandom_range(0, 99) < pc);
      v0 = ($urandom_range(0, 99) < 60);
      v1 = ($urandom_range(0, 99) < 40);
      if (m_count > 0 && $urandom_range(0, 9) < 8) begin
        i0 = (m_head + $urandom_range(0, m_count - 1)) % 16;
        i1 = (m_head + $urandom_range(0, m_count - 1)) % 16;
      end else begin
        i0 = $urandom_range(0, 15);
        i1 = $urandom_range(0, 15);
      end
      step(r, f, a, b, v0, i0, v1, i1, ce);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
